// File: rtl/mult_host_ctrl.sv
// mult_host_ctrl: initiator for the shift-add multiplier handshake, with a one-entry
// operand buffer, held result with ready/valid, WAIT latency counter and sticky watchdog.
module mult_host_ctrl #(
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iReq_Valid,
    input  logic [WIDTH-1:0]   iReq_A,
    input  logic [WIDTH-1:0]   iReq_B,
    output logic               oReq_Ready,
    output logic [WIDTH-1:0]   oData_A,
    output logic [WIDTH-1:0]   oData_B,
    output logic               oValid_Data,
    input  logic               iDone,
    input  logic [2*WIDTH-1:0] iProduct,
    output logic               oAck,
    output logic [2*WIDTH-1:0] oResult,
    output logic [CNT_W-1:0]   oCycles,
    output logic               oResult_Valid,
    input  logic               iResult_Ready,
    output logic               oTimeout
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, HOLD} state_e;

    state_e             state_q, state_d;
    logic               buf_full_q, buf_full_d;
    logic [WIDTH-1:0]   buf_a_q, buf_a_d, buf_b_q, buf_b_d;
    logic [WIDTH-1:0]   data_a_q, data_a_d, data_b_q, data_b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cycles_q, cycles_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               captured_q, captured_d, timeout_q, timeout_d;
    logic               accept;

    assign accept = iReq_Valid && !buf_full_q;

    always_comb begin
        state_d    = state_q;
        buf_full_d = accept ? 1'b1 : (state_q == IDLE ? 1'b0 : buf_full_q);
        buf_a_d    = accept ? iReq_A : buf_a_q;
        buf_b_d    = accept ? iReq_B : buf_b_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        cnt_d      = cnt_q;
        cycles_d   = cycles_q;
        result_d   = result_q;
        captured_d = captured_q;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: if (buf_full_q) begin
                data_a_d = buf_a_q;
                data_b_d = buf_b_q;
                state_d  = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // a product arriving on the watchdog's last cycle still counts as success
                if (iDone) begin
                    result_d   = iProduct;
                    cycles_d   = cnt_q;
                    captured_d = 1'b1;
                    state_d    = ACK;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d  = 1'b1;
                    captured_d = 1'b0;
                    state_d    = ACK;
                end
            end
            ACK:     state_d = captured_q ? HOLD : IDLE;
            HOLD:    state_d = iResult_Ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            buf_full_q <= 1'b0;
            buf_a_q    <= '0;
            buf_b_q    <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            cnt_q      <= '0;
            cycles_q   <= '0;
            result_q   <= '0;
            captured_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_a_q    <= buf_a_d;
            buf_b_q    <= buf_b_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            cnt_q      <= cnt_d;
            cycles_q   <= cycles_d;
            result_q   <= result_d;
            captured_q <= captured_d;
            timeout_q  <= timeout_d;
        end
    end

    assign oReq_Ready    = !buf_full_q;
    assign oData_A       = data_a_q;
    assign oData_B       = data_b_q;
    assign oValid_Data   = state_q == ISSUE;
    assign oAck          = state_q == ACK;
    assign oResult_Valid = state_q == HOLD;
    assign oResult       = result_q;
    assign oCycles       = cycles_q;
    assign oTimeout      = timeout_q;
endmodule

// File: tb/tb_mult_host_ctrl.sv
// tb_mult_host_ctrl: scoreboard bench with a delay-programmable multiplier model and
// a result consumer that holds off iResult_Ready for a programmable number of cycles.
module tb_mult_host_ctrl;
    localparam int W = 32;

    logic           Clock = 1'b0;
    logic           Reset = 1'b0;
    logic           iReq_Valid = 1'b0;
    logic [W-1:0]   iReq_A = '0;
    logic [W-1:0]   iReq_B = '0;
    logic           oReq_Ready;
    logic [W-1:0]   oData_A, oData_B;
    logic           oValid_Data;
    logic           iDone;
    logic [2*W-1:0] iProduct;
    logic           oAck;
    logic [2*W-1:0] oResult;
    logic [7:0]     oCycles;
    logic           oResult_Valid;
    logic           iResult_Ready = 1'b0;
    logic           oTimeout;

    logic           mul_done = 1'b0;
    logic           stray_done = 1'b0;
    logic [63:0]    mul_prod = '0;

    typedef struct packed {
        logic [63:0] prod;
        logic [7:0]  cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          delay_q[$];
    int          checks = 0, errors = 0, ack_cnt = 0, hold_cycles = 1, vcnt = 0;
    logic        prev_vd = 1'b0, prev_ack = 1'b0, prev_rv = 1'b0;
    logic [63:0] held_res = '0;
    logic [7:0]  held_cyc = '0;

    assign iDone    = mul_done | stray_done;
    assign iProduct = mul_done ? mul_prod : 64'hBAD0_BAD0_BAD0_BAD0;

    mult_host_ctrl dut (
        .Clock(Clock), .Reset(Reset),
        .iReq_Valid(iReq_Valid), .iReq_A(iReq_A), .iReq_B(iReq_B), .oReq_Ready(oReq_Ready),
        .oData_A(oData_A), .oData_B(oData_B), .oValid_Data(oValid_Data),
        .iDone(iDone), .iProduct(iProduct), .oAck(oAck),
        .oResult(oResult), .oCycles(oCycles), .oResult_Valid(oResult_Valid),
        .iResult_Ready(iResult_Ready), .oTimeout(oTimeout)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // multiplier model: iDone is sampled on the (d+1)-th edge after ISSUE exit, so oCycles = d
    initial begin
        int d;
        forever begin
            @(negedge Clock);
            if (oValid_Data && Reset) begin
                if (delay_q.size() == 0) check("issue_unexpected", 1, 0);
                else begin
                    d = delay_q.pop_front();
                    if (d >= 0) begin
                        mul_prod = 64'(oData_A) * 64'(oData_B);
                        repeat (d + 1) @(negedge Clock);
                        mul_done = 1'b1;
                        @(negedge Clock);
                        mul_done = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge Clock) begin
        exp_t e;
        if (oAck) begin
            check("ack_pulse", 64'(prev_ack), 0);
            ack_cnt++;
        end
        if (oValid_Data) check("vd_pulse", 64'(prev_vd), 0);
        if (oResult_Valid && !prev_rv) begin
            if (exp_q.size() == 0) check("unexpected_result", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("result", oResult, e.prod);
                check("cycles", 64'(oCycles), 64'(e.cyc));
            end
            held_res = oResult;
            held_cyc = oCycles;
        end else if (oResult_Valid) begin
            check("hold_result", oResult, held_res);
            check("hold_cycles", 64'(oCycles), 64'(held_cyc));
        end
        vcnt          = oResult_Valid ? vcnt + 1 : 0;
        iResult_Ready = oResult_Valid && vcnt >= hold_cycles;
        prev_ack      = oAck;
        prev_vd       = oValid_Data;
        prev_rv       = oResult_Valid;
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input int d, input bit lat);
        int   n = 0;
        exp_t e;
        while (!oReq_Ready && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("req_ready_wait", 64'(oReq_Ready), 1);
        iReq_Valid = 1'b1;
        iReq_A     = a;
        iReq_B     = b;
        delay_q.push_back(d);
        if (d >= 0) begin
            e.prod = 64'(a) * 64'(b);
            e.cyc  = 8'(d);
            exp_q.push_back(e);
        end
        @(negedge Clock);
        iReq_Valid = 1'b0;
        check("ready_low", 64'(oReq_Ready), 0);
        if (lat) begin
            @(negedge Clock);
            check("issue_vd", 64'(oValid_Data), 1);
            check("issue_a", 64'(oData_A), 64'(a));
            check("issue_b", 64'(oData_B), 64'(b));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || delay_q.size() != 0 || oResult_Valid || mul_done) && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        check("drain", 64'(n < 2000), 1);
        repeat (3) @(negedge Clock);
    endtask

    initial begin
        int a0, n;
        repeat (2) @(negedge Clock);
        check("rst_ready", 64'(oReq_Ready), 1);
        check("rst_vd", 64'(oValid_Data), 0);
        check("rst_ack", 64'(oAck), 0);
        check("rst_rv", 64'(oResult_Valid), 0);
        check("rst_result", oResult, 0);
        check("rst_cycles", 64'(oCycles), 0);
        check("rst_timeout", 64'(oTimeout), 0);
        check("rst_data", {oData_A, oData_B}, 0);
        Reset = 1'b1;
        @(negedge Clock);

        a0 = ack_cnt;
        send('1, '1, 33, 1);
        drain();
        check("max_acks", 64'(ack_cnt - a0), 1);
        check("max_result", oResult, 64'hFFFF_FFFE_0000_0001);
        check("max_cycles", 64'(oCycles), 33);

        // abort in the middle of WAIT
        a0 = ack_cnt;
        send(32'd5, 32'd6, -1, 1);
        repeat (10) @(negedge Clock);
        #1 Reset = 1'b0;
        #1;
        check("arst_ready", 64'(oReq_Ready), 1);
        check("arst_vd", 64'(oValid_Data), 0);
        check("arst_ack", 64'(oAck), 0);
        check("arst_rv", 64'(oResult_Valid), 0);
        check("arst_result", oResult, 0);
        check("arst_cycles", 64'(oCycles), 0);
        check("arst_data", {oData_A, oData_B}, 0);
        check("arst_timeout", 64'(oTimeout), 0);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        check("arst_no_ack", 64'(ack_cnt - a0), 0);

        // second pair buffered behind the first; first result held 10 cycles
        hold_cycles = 10;
        a0 = ack_cnt;
        send(32'd0, '1, 5, 1);
        send(32'd10000, 32'd4500, 7, 0);
        drain();
        check("buf_acks", 64'(ack_cnt - a0), 2);
        hold_cycles = 1;

        a0 = ack_cnt;
        stray_done = 1'b1;
        repeat (2) @(negedge Clock);
        stray_done = 1'b0;
        repeat (3) @(negedge Clock);
        check("idle_done_ack", 64'(ack_cnt - a0), 0);
        check("idle_done_vd", 64'(oValid_Data), 0);
        check("idle_done_result", oResult, 64'd45000000);

        hold_cycles = 8;
        a0 = ack_cnt;
        send(32'd3, 32'd5, 2, 0);
        n = 0;
        while (!oResult_Valid && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("hold_seen", 64'(oResult_Valid), 1);
        stray_done = 1'b1;
        repeat (2) @(negedge Clock);
        stray_done = 1'b0;
        drain();
        check("hold_done_acks", 64'(ack_cnt - a0), 1);
        hold_cycles = 1;

        send(32'd7, 32'd9, 0, 0);
        drain();

        // watchdog: no iDone ever
        a0 = ack_cnt;
        send(32'd11, 32'd13, -1, 0);
        n = 0;
        while (!oValid_Data && n < 100) begin
            @(negedge Clock);
            n++;
        end
        n = 0;
        while (!oTimeout && n < 400) begin
            @(negedge Clock);
            n++;
        end
        check("timeout_cycles", 64'(n), 256);
        check("timeout_ack", 64'(oAck), 1);
        repeat (5) @(negedge Clock);
        check("timeout_acks", 64'(ack_cnt - a0), 1);
        check("timeout_rv", 64'(oResult_Valid), 0);

        a0 = ack_cnt;
        send(32'd123456, 32'd789, 3, 0);
        drain();
        check("sticky_timeout", 64'(oTimeout), 1);
        check("sticky_acks", 64'(ack_cnt - a0), 1);
        check("queue_empty", 64'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
